mem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port data/instruction memory of the multicycle CPU. Port 0 is the CPU controller's fetch/load/store path. Port 1 is the program loader / debug port. The block serialises their requests, drives the memory with a parameterised number of wait cycles, and returns read data with a one-cycle acknowledge pulse per requester.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the CPU's single-port memory.
// Port 0 is the CPU fetch/load/store path, port 1 the loader/debug path.
module mem_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int WAIT_CYC  = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    logic        last_gnt;
    logic [3:0]  cnt;
    logic        we_q;
    logic        sel_valid;
    logic        sel_port;

    // On a tie, round-robin favours the port that was not served last.
    always_comb begin
        sel_valid = req0 | req1;
        sel_port  = 1'b0;
        if (req0 && req1)
            sel_port = (PRIO_MODE != 0) ? 1'b0 : ~last_gnt;
        else if (req1)
            sel_port = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            cnt       <= '0;
            we_q      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state     <= ACCESS;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_addr  <= sel_port ? addr1 : addr0;
                        mem_wdata <= sel_port ? wdata1 : wdata0;
                        we_q      <= sel_port ? we1 : we0;
                        mem_we    <= sel_port ? we1 : we0;
                        gnt0      <= ~sel_port;
                        gnt1      <= sel_port;
                        last_gnt  <= sel_port;
                        cnt       <= 4'(WAIT_CYC);
                    end
                end
                ACCESS: begin
                    // Write strobe is confined to the first access cycle.
                    mem_we <= 1'b0;
                    if (cnt == '0) begin
                        if (!we_q)
                            rdata <= mem_rdata;
                        state  <= DONE;
                        mem_en <= 1'b0;
                        ack0   <= gnt0;
                        ack1   <= gnt1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ack0   <= 1'b0;
                    ack1   <= 1'b0;
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is round-robin with WAIT_CYC=1,
// instance 1 is fixed priority with WAIT_CYC=3; each has a small memory model.
module tb_mem_arbiter;

    localparam int W0 = 1;
    localparam int W1 = 3;

    typedef struct {
        bit         port;
        logic [7:0] rdata;
    } exp_t;

    typedef struct {
        bit          port;
        bit          we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req0 [2];
    logic        we0  [2];
    logic [12:0] addr0 [2];
    logic [7:0]  wdata0 [2];
    logic        req1 [2];
    logic        we1  [2];
    logic [12:0] addr1 [2];
    logic [7:0]  wdata1 [2];
    logic        ack0 [2];
    logic        ack1 [2];
    logic        gnt0 [2];
    logic        gnt1 [2];
    logic [7:0]  rdata [2];
    logic        busy [2];
    logic        mem_en [2];
    logic        mem_we [2];
    logic [12:0] mem_addr [2];
    logic [7:0]  mem_wdata [2];
    logic [7:0]  mem_rdata [2];

    int unsigned acc_cyc [2];
    int          en_total [2];
    int          we_total [2];
    int          ack_total [2];
    logic        en_prev [2];
    logic [12:0] start_addr [2];
    logic [12:0] last_addr [2];
    logic [7:0]  we_data [2];
    int          viol;

    int   tests;
    int   fails;
    int   pops [2];
    exp_t sb0 [$];
    exp_t sb1 [$];
    vec_t tbl [6];

    mem_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(W0), .PRIO_MODE(0)) dut_rr (
        .clk(clk), .rst(rst),
        .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
        .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .gnt0(gnt0[0]), .gnt1(gnt1[0]),
        .rdata(rdata[0]), .busy(busy[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(W1), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
        .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .gnt0(gnt0[1]), .gnt1(gnt1[1]),
        .rdata(rdata[1]), .busy(busy[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory data is only valid in the last access cycle; earlier cycles return junk.
    assign mem_rdata[0] = (mem_en[0] && acc_cyc[0] == W0) ? (mem_addr[0][7:0] ^ 8'h99)
                                                          : (8'hEE ^ 8'(acc_cyc[0]));
    assign mem_rdata[1] = (mem_en[1] && acc_cyc[1] == W1) ? (mem_addr[1][7:0] ^ 8'h99)
                                                          : (8'hEE ^ 8'(acc_cyc[1]));

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            acc_cyc[i] <= mem_en[i] ? acc_cyc[i] + 1 : 0;
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            en_total[i] = 0; we_total[i] = 0; ack_total[i] = 0; en_prev[i] = 1'b0;
            start_addr[i] = '0; last_addr[i] = '0; we_data[i] = '0; acc_cyc[i] = 0;
        end
        viol = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_en[i]) begin
                if (!en_prev[i]) start_addr[i] <= mem_addr[i];
                last_addr[i] <= mem_addr[i];
                en_total[i]  <= en_total[i] + 1;
            end
            en_prev[i] <= mem_en[i];
            if (mem_we[i]) begin
                we_total[i] <= we_total[i] + 1;
                we_data[i]  <= mem_wdata[i];
            end
            if (ack0[i] || ack1[i]) ack_total[i] <= ack_total[i] + 1;
        end
        if ((ack0[0] & ack1[0]) | (gnt0[0] & gnt1[0]) | (mem_we[0] & ~mem_en[0]) |
            (ack0[1] & ack1[1]) | (gnt0[1] & gnt1[1]) | (mem_we[1] & ~mem_en[1]))
            viol <= viol + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input bit port, input logic [7:0] rd);
        exp_t e;
        e.port  = port;
        e.rdata = rd;
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic drive(input int i, input bit port, input bit we,
                         input logic [12:0] addr, input logic [7:0] wd);
        req0[i] = 1'b0;
        req1[i] = 1'b0;
        if (port) begin
            req1[i] = 1'b1; we1[i] = we; addr1[i] = addr; wdata1[i] = wd;
        end else begin
            req0[i] = 1'b1; we0[i] = we; addr0[i] = addr; wdata0[i] = wd;
        end
    endtask

    // Wait for the next ack on instance i, then pop and compare the scoreboard.
    task automatic wait_ack(input int i, output int c);
        bit   got;
        exp_t e;
        int   pending;
        got = 1'b0;
        c   = 0;
        while (!got && c < 40) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (ack0[i] || ack1[i]) got = 1'b1;
        end
        chk($sformatf("ack_seen[%0d]", i), 64'(got), 64'd1);
        if (got) begin
            pending = (i == 0) ? sb0.size() : sb1.size();
            chk($sformatf("sb_pending[%0d]", i), 64'(pending > 0), 64'd1);
            if (pending > 0) begin
                e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                pops[i]++;
                chk($sformatf("ack_port[%0d]", i), 64'(ack1[i]), 64'(e.port));
                chk($sformatf("rdata[%0d]", i), 64'(rdata[i]), 64'(e.rdata));
            end
        end
    endtask

    initial begin
        int c;
        int en_s;
        int we_s;

        tests = 0; fails = 0; pops[0] = 0; pops[1] = 0;
        tbl[0] = '{1'b0, 1'b0, 13'h00A5, 8'h00, 8'h3C};
        tbl[1] = '{1'b1, 1'b1, 13'h1FFF, 8'hA5, 8'h3C};
        tbl[2] = '{1'b0, 1'b1, 13'h0000, 8'hFF, 8'h3C};
        tbl[3] = '{1'b1, 1'b0, 13'h1234, 8'h00, 8'hAD};
        tbl[4] = '{1'b0, 1'b0, 13'h1FFF, 8'h00, 8'h66};
        tbl[5] = '{1'b1, 1'b1, 13'h0001, 8'h00, 8'h66};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req0[i] = 0; we0[i] = 0; addr0[i] = '0; wdata0[i] = '0;
            req1[i] = 0; we1[i] = 0; addr1[i] = '0; wdata1[i] = '0;
        end
        #2 rst = 1'b0;
        #10;
        for (int i = 0; i < 2; i++)
            chk($sformatf("reset_outs[%0d]", i),
                {28'd0, ack0[i], ack1[i], gnt0[i], gnt1[i], busy[i], mem_en[i], mem_we[i],
                 rdata[i], mem_addr[i], mem_wdata[i]}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Round-robin contention from reset: 0,1,0,1 spaced four cycles apart.
        req0[0] = 1; addr0[0] = 13'h010; req1[0] = 1; addr1[0] = 13'h020;
        push(0, 0, 8'h89); push(0, 1, 8'hB9); push(0, 0, 8'h89); push(0, 1, 8'hB9);
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, c);
            chk(k == 0 ? "rr_first_latency" : "rr_spacing", 64'(c), k == 0 ? 64'd3 : 64'd4);
        end
        @(posedge clk); #1;
        req0[0] = 0; req1[0] = 0;

        // Single accesses from the vector table.
        for (int v = 0; v < 6; v++) begin
            @(posedge clk); #1;
            en_s = en_total[0];
            we_s = we_total[0];
            drive(0, tbl[v].port, tbl[v].we, tbl[v].addr, tbl[v].wdata);
            push(0, tbl[v].port, tbl[v].exp_rdata);
            wait_ack(0, c);
            chk($sformatf("vec%0d_latency", v), 64'(c), 64'd3);
            chk($sformatf("vec%0d_en_cycles", v), 64'(en_total[0] - en_s), 64'd2);
            chk($sformatf("vec%0d_we_cycles", v), 64'(we_total[0] - we_s), 64'(tbl[v].we));
            chk($sformatf("vec%0d_addr", v), 64'(start_addr[0]), 64'(tbl[v].addr));
            if (tbl[v].we)
                chk($sformatf("vec%0d_wdata", v), 64'(we_data[0]), 64'(tbl[v].wdata));
        end
        @(posedge clk); #1;
        req0[0] = 0; req1[0] = 0;

        // Fixed priority: port 1 starves until port 0 lets go.
        req0[1] = 1; we0[1] = 0; addr0[1] = 13'h0A5;
        req1[1] = 1; we1[1] = 0; addr1[1] = 13'h055;
        push(1, 0, 8'h3C); push(1, 0, 8'h3C); push(1, 0, 8'h3C); push(1, 1, 8'hCC);
        for (int k = 0; k < 3; k++) begin
            wait_ack(1, c);
            chk(k == 0 ? "fp_first_latency" : "fp_spacing", 64'(c), k == 0 ? 64'd5 : 64'd6);
        end
        @(posedge clk); #1;
        req0[1] = 0;
        wait_ack(1, c);
        chk("fp_port1_after_drop", 64'(c), 64'd5);
        @(posedge clk); #1;
        req1[1] = 0;

        // WAIT_CYC=3 read; address changes and req drops once the access has started.
        @(posedge clk); #1;
        en_s = en_total[1];
        drive(1, 0, 0, 13'h0F0, 8'h00);
        push(1, 0, 8'h69);
        @(posedge clk); #1;
        addr0[1] = 13'h1AAA;
        req0[1]  = 0;
        wait_ack(1, c);
        chk("w3_latency", 64'(c + 1), 64'd5);
        chk("w3_en_cycles", 64'(en_total[1] - en_s), 64'd4);
        chk("w3_addr_first", 64'(start_addr[1]), 64'h0F0);
        chk("w3_addr_last", 64'(last_addr[1]), 64'h0F0);

        // Asynchronous reset in the first cycle of a write aborts it with no ack.
        @(posedge clk); #1;
        drive(0, 0, 1, 13'h100, 8'h5A);
        @(posedge clk); #2;
        chk("pre_abort_we", 64'(mem_we[0]), 64'd1);
        rst = 1'b0;
        #1;
        chk("abort_outs", {57'd0, mem_en[0], mem_we[0], gnt0[0], gnt1[0], busy[0], ack0[0], ack1[0]},
            64'd0);
        we0[0] = 0;
        req1[0] = 1; we1[0] = 0; addr1[0] = 13'h0C3;
        push(0, 0, 8'h99); push(0, 1, 8'h5A);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wait_ack(0, c);
        chk("post_reset_latency", 64'(c), 64'd3);
        wait_ack(0, c);
        chk("post_reset_spacing", 64'(c), 64'd4);
        @(posedge clk); #1;
        req0[0] = 0; req1[0] = 0;

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("ack_count[0]", 64'(ack_total[0]), 64'(pops[0]));
        chk("ack_count[1]", 64'(ack_total[1]), 64'(pops[1]));
        chk("invariants", 64'(viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
